// File: rtl/tictactoe_pkg.sv
// tictactoe_pkg: shared state encoding, winner codes, cell indices and win-line table
package tictactoe_pkg;
   typedef enum logic [2:0] {IDLE, P1_WAIT, P2_WAIT, CHECK, DONE} state_t;
   typedef enum logic [1:0] {WIN_NONE = 2'b00, WIN_P1 = 2'b01, WIN_P2 = 2'b10} winner_t;
   localparam int CELL_A = 0;
   localparam int CELL_B = 1;
   localparam int CELL_C = 2;
   localparam int CELL_D = 3;
   localparam int CELL_E = 4;
   localparam int CELL_F = 5;
   localparam int CELL_G = 6;
   localparam int CELL_H = 7;
   localparam int CELL_I = 8;
   // index 0..7 = abc, def, ghi, adg, beh, cfi, aei, ceg
   localparam logic [7:0][8:0] WIN_LINES = {9'h054, 9'h111, 9'h124, 9'h092,
                                           9'h049, 9'h1C0, 9'h038, 9'h007};
endpackage

// File: rtl/win_check.sv
// win_check: flags whether a 9-bit mark vector completes any of the 8 lines
module win_check
   import tictactoe_pkg::*;
(
   input  logic [8:0] marks,
   output logic       win
);
   always_comb begin
      win = 1'b0;
      for (int k = 0; k < 8; k++) win = win | ((marks & WIN_LINES[k]) == WIN_LINES[k]);
   end
endmodule

// File: rtl/game_fsm.sv
// game_fsm: two-player tic-tac-toe controller with registered edge-detected cell buttons
module game_fsm
   import tictactoe_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       a_button,
   input  logic       b_button,
   input  logic       c_button,
   input  logic       d_button,
   input  logic       e_button,
   input  logic       f_button,
   input  logic       g_button,
   input  logic       h_button,
   input  logic       i_button,
   input  logic       game_mode,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   output logic       e,
   output logic       f,
   output logic       g,
   output logic       h,
   output logic       i,
   output logic [8:0] cells_x,
   output logic [8:0] cells_o,
   output logic       p1_turn,
   output logic       ai_mode,
   output logic [1:0] winner,
   output logic       draw,
   output logic       game_over,
   output logic [3:0] move_count
);
   state_t     state, state_n;
   winner_t    winner_q, winner_n;
   logic [8:0] btn_cur, btn_prev, press, occ;
   logic [8:0] cells_x_n, cells_o_n;
   logic [3:0] count_n;
   logic       draw_n, over_n, ai_n, mover, mover_n, valid, line_win;
   assign occ = cells_x | cells_o;
   assign {i, h, g, f, e, d, c, b, a} = occ;
   assign press = btn_cur & ~btn_prev;
   assign valid = $onehot(press) && ((press & occ) == 9'd0);
   assign p1_turn = (state == P1_WAIT);
   assign winner = winner_q;
   // mover: 0 = P1 made the last mark, 1 = P2
   win_check u_win_check (.marks(mover ? cells_o : cells_x), .win(line_win));
   always_comb begin
      state_n   = state;
      cells_x_n = cells_x;
      cells_o_n = cells_o;
      count_n   = move_count;
      winner_n  = winner_q;
      draw_n    = draw;
      over_n    = game_over;
      ai_n      = ai_mode;
      mover_n   = mover;
      if (start) begin
         state_n   = P1_WAIT;
         cells_x_n = 9'd0;
         cells_o_n = 9'd0;
         count_n   = 4'd0;
         winner_n  = WIN_NONE;
         draw_n    = 1'b0;
         over_n    = 1'b0;
         ai_n      = game_mode;
         mover_n   = 1'b0;
      end else begin
         case (state)
            P1_WAIT: if (valid) begin
               cells_x_n = cells_x | press;
               count_n   = move_count + 4'd1;
               mover_n   = 1'b0;
               state_n   = CHECK;
            end
            P2_WAIT: if (valid) begin
               cells_o_n = cells_o | press;
               count_n   = move_count + 4'd1;
               mover_n   = 1'b1;
               state_n   = CHECK;
            end
            CHECK: begin
               if (line_win) begin
                  winner_n = mover ? WIN_P2 : WIN_P1;
                  over_n   = 1'b1;
                  state_n  = DONE;
               end else if (move_count == 4'd9) begin
                  draw_n  = 1'b1;
                  over_n  = 1'b1;
                  state_n = DONE;
               end else begin
                  state_n = mover ? P1_WAIT : P2_WAIT;
               end
            end
            IDLE, DONE: state_n = state;
            default: state_n = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cells_x    <= 9'd0;
         cells_o    <= 9'd0;
         move_count <= 4'd0;
         winner_q   <= WIN_NONE;
         draw       <= 1'b0;
         game_over  <= 1'b0;
         ai_mode    <= 1'b0;
         mover      <= 1'b0;
         btn_cur    <= 9'd0;
         btn_prev   <= 9'd0;
      end else begin
         state      <= state_n;
         cells_x    <= cells_x_n;
         cells_o    <= cells_o_n;
         move_count <= count_n;
         winner_q   <= winner_n;
         draw       <= draw_n;
         game_over  <= over_n;
         ai_mode    <= ai_n;
         mover      <= mover_n;
         btn_cur    <= {i_button, h_button, g_button, f_button, e_button,
                        d_button, c_button, b_button, a_button};
         btn_prev   <= btn_cur;
      end
   end
endmodule

// File: tb/tb_game_fsm.sv
// tb_game_fsm: directed scenario tests for game_fsm with hand-computed expectations
module tb_game_fsm;
   import tictactoe_pkg::*;
   logic       clk = 1'b0, reset = 1'b0, start = 1'b0, game_mode = 1'b0;
   logic [8:0] btn = 9'd0, occ, cells_x, cells_o;
   logic       p1_turn, ai_mode, draw, game_over;
   logic [1:0] winner;
   logic [3:0] move_count;
   int         vectors = 0, errors = 0;

   game_fsm dut (
      .clk(clk), .reset(reset), .start(start),
      .a_button(btn[0]), .b_button(btn[1]), .c_button(btn[2]),
      .d_button(btn[3]), .e_button(btn[4]), .f_button(btn[5]),
      .g_button(btn[6]), .h_button(btn[7]), .i_button(btn[8]),
      .game_mode(game_mode),
      .a(occ[0]), .b(occ[1]), .c(occ[2]), .d(occ[3]), .e(occ[4]),
      .f(occ[5]), .g(occ[6]), .h(occ[7]), .i(occ[8]),
      .cells_x(cells_x), .cells_o(cells_o), .p1_turn(p1_turn),
      .ai_mode(ai_mode), .winner(winner), .draw(draw),
      .game_over(game_over), .move_count(move_count)
   );

   always #5 clk = ~clk;

   task automatic start_game(input logic mode);
      @(negedge clk);
      start = 1'b1;
      game_mode = mode;
      @(negedge clk);
      start = 1'b0;
   endtask

   // full move: press edge, write edge, CHECK edge; returns at the negedge after CHECK
   task automatic move(input int idx);
      @(negedge clk);
      btn[idx] = 1'b1;
      @(negedge clk);
      btn[idx] = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset;
      @(negedge clk);
      reset = 1'b1;
      btn = 9'h1FF;
      start = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      btn = 9'd0;
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      vectors++; if ({cells_x, cells_o, occ} !== 27'd0) begin errors++; $display("FAIL reset_cells: got %h/%h/%h, expected 0", cells_x, cells_o, occ); end
      vectors++; if ({p1_turn, ai_mode, winner, draw, game_over, move_count} !== 10'd0) begin errors++; $display("FAIL reset_flags: got %b %b %b %b %b %0d, expected all 0", p1_turn, ai_mode, winner, draw, game_over, move_count); end
      vectors++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d, expected %0d", dut.state, IDLE); end
   endtask

   task automatic test_first_move;
      start_game(1'b0);
      vectors++; if (p1_turn !== 1'b1 || dut.state !== P1_WAIT) begin errors++; $display("FAIL start_p1_wait: got p1_turn %b state %0d, expected 1 %0d", p1_turn, dut.state, P1_WAIT); end
      @(negedge clk);
      btn[4] = 1'b1;
      @(negedge clk);
      btn[4] = 1'b0;
      @(negedge clk);
      vectors++; if (cells_x !== 9'h010 || move_count !== 4'd1) begin errors++; $display("FAIL first_move: got cells_x %h count %0d, expected 010 1", cells_x, move_count); end
      vectors++; if (p1_turn !== 1'b0) begin errors++; $display("FAIL first_move_turn: got %b, expected 0", p1_turn); end
      @(negedge clk);
      vectors++; if (dut.state !== P2_WAIT || occ !== 9'h010) begin errors++; $display("FAIL first_move_p2: got state %0d occ %h, expected %0d 010", dut.state, occ, P2_WAIT); end
   endtask

   task automatic test_p1_win;
      start_game(1'b0);
      move(0); move(3); move(1); move(4); move(2);
      vectors++; if (winner !== 2'b01 || game_over !== 1'b1 || draw !== 1'b0) begin errors++; $display("FAIL p1_win: got winner %b over %b draw %b, expected 01 1 0", winner, game_over, draw); end
      vectors++; if (dut.state !== DONE) begin errors++; $display("FAIL p1_win_state: got %0d, expected %0d", dut.state, DONE); end
      vectors++; if (cells_x !== 9'h007 || cells_o !== 9'h018 || move_count !== 4'd5) begin errors++; $display("FAIL p1_win_cells: got %h %h %0d, expected 007 018 5", cells_x, cells_o, move_count); end
      move(8);
      vectors++; if (cells_x !== 9'h007 || cells_o !== 9'h018 || move_count !== 4'd5) begin errors++; $display("FAIL done_press: got %h %h %0d, expected 007 018 5", cells_x, cells_o, move_count); end
   endtask

   task automatic test_occupied_and_multi;
      start_game(1'b0);
      move(4);
      move(4);
      vectors++; if (cells_x !== 9'h010 || cells_o !== 9'h000 || move_count !== 4'd1 || p1_turn !== 1'b0) begin errors++; $display("FAIL occupied: got %h %h %0d %b, expected 010 000 1 0", cells_x, cells_o, move_count, p1_turn); end
      @(negedge clk);
      btn[1:0] = 2'b11;
      @(negedge clk);
      btn[1:0] = 2'b00;
      repeat (2) @(negedge clk);
      vectors++; if (cells_o !== 9'h000 || move_count !== 4'd1 || dut.state !== P2_WAIT) begin errors++; $display("FAIL double_press: got %h %0d state %0d, expected 000 1 %0d", cells_o, move_count, dut.state, P2_WAIT); end
      @(negedge clk);
      btn[0] = 1'b1;
      repeat (5) @(negedge clk);
      btn[0] = 1'b0;
      repeat (2) @(negedge clk);
      vectors++; if (cells_o !== 9'h001 || move_count !== 4'd2 || p1_turn !== 1'b1) begin errors++; $display("FAIL held_button: got %h %0d %b, expected 001 2 1", cells_o, move_count, p1_turn); end
   endtask

   task automatic test_draw;
      start_game(1'b0);
      move(4); move(0); move(2); move(6); move(3); move(5); move(1); move(7); move(8);
      vectors++; if (draw !== 1'b1 || winner !== 2'b00 || game_over !== 1'b1) begin errors++; $display("FAIL draw: got draw %b winner %b over %b, expected 1 00 1", draw, winner, game_over); end
      vectors++; if (move_count !== 4'd9 || cells_x !== 9'h11E || cells_o !== 9'h0E1) begin errors++; $display("FAIL draw_cells: got %0d %h %h, expected 9 11e 0e1", move_count, cells_x, cells_o); end
   endtask

   task automatic test_reset_mid_game;
      start_game(1'b0);
      move(4);
      @(negedge clk);
      btn[0] = 1'b1;
      @(negedge clk);
      btn[0] = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      vectors++; if ({cells_x, cells_o, move_count, p1_turn, winner, game_over, draw} !== 27'd0 || dut.state !== IDLE) begin errors++; $display("FAIL reset_mid: got %h %h %0d state %0d, expected 0 0 0 %0d", cells_x, cells_o, move_count, dut.state, IDLE); end
      start_game(1'b1);
      game_mode = 1'b0;
      @(negedge clk);
      vectors++; if (dut.state !== P1_WAIT || ai_mode !== 1'b1) begin errors++; $display("FAIL restart_ai: got state %0d ai %b, expected %0d 1", dut.state, ai_mode, P1_WAIT); end
      btn[0] = 1'b1;
      @(negedge clk);
      btn[0] = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vectors++; if (cells_x !== 9'h000 || move_count !== 4'd0 || p1_turn !== 1'b1 || ai_mode !== 1'b0) begin errors++; $display("FAIL start_priority: got %h %0d %b %b, expected 000 0 1 0", cells_x, move_count, p1_turn, ai_mode); end
   endtask

   initial begin
      test_reset;
      test_first_move;
      test_p1_win;
      test_occupied_and_multi;
      test_draw;
      test_reset_mid_game;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/game_fsm.md
GAME_FSM -- requirements
Module: game_fsm

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, level; clears the board and begins a new game; P1 moves first.
REQ-004 SHALL have ports a_button..i_button, input, 1 each, cell-select requests from the player or the ai stage; level signals, sampled for rising edges.
REQ-005 SHALL have port game_mode, input, 1; 1 = P2 is the ai stage; registered into the block only at game start.
REQ-006 SHALL have ports a..i, output, 1 each, cell occupied (either player); these feed the ai stage directly.
REQ-007 SHALL have port cells_x, output, 9, P1 marks; bit0 = a ... bit8 = i.
REQ-008 SHALL have port cells_o, output, 9, P2 marks; same bit order.
REQ-009 SHALL have port p1_turn, output, 1; high while the FSM waits for a P1 move.
REQ-010 SHALL have port ai_mode, output, 1, latched game_mode.
REQ-011 SHALL have port winner, output, 2; 00 none, 01 P1, 10 P2.
REQ-012 SHALL have ports draw and game_over, output, 1 each.
REQ-013 SHALL have port move_count, output, 4, number of marks placed (0..9).

Function
REQ-014 SHALL implement the states IDLE, P1_WAIT, P2_WAIT, CHECK and DONE.
REQ-015 SHALL register each button and detect a press as current=1 and previous=0; a held button SHALL count once.
REQ-016 In P1_WAIT or P2_WAIT, a single valid press on an empty cell SHALL set that cell's bit in cells_x (P1) or cells_o (P2), increment move_count and enter CHECK, all on the clock edge that follows the detection cycle.
REQ-017 Presses on occupied cells SHALL be ignored; the FSM SHALL stay in its wait state.
REQ-018 Two or more presses detected in the same cycle SHALL all be ignored.
REQ-019 Presses in IDLE, CHECK or DONE SHALL be ignored, and their edge history SHALL still update.
REQ-020 CHECK SHALL last exactly one cycle and evaluate the 8 lines (abc, def, ghi, adg, beh, cfi, aei, ceg) for the player who just moved.
REQ-021 On a line match, CHECK SHALL set winner to that player, set game_over and enter DONE.
REQ-022 With no line match and move_count = 9, CHECK SHALL set draw and game_over and enter DONE.
REQ-023 Otherwise CHECK SHALL enter the other player's wait state.
REQ-024 A win on the 9th move SHALL report the win only, with draw = 0.
REQ-025 start, sampled high in any state, SHALL on the next edge clear cells_x, cells_o, move_count, winner, draw and game_over, latch ai_mode, and enter P1_WAIT.
REQ-026 start SHALL take priority over a simultaneous press.
REQ-027 p1_turn SHALL be 1 only in P1_WAIT; outputs a..i SHALL equal cells_x | cells_o.
REQ-028 cells_x & cells_o SHALL always be zero.
REQ-029 move_count SHALL never exceed 9.

Reset
REQ-030 On reset = 1 at a clock edge, the block SHALL enter IDLE with all outputs 0 and the button history cleared to 0.
REQ-031 Reset SHALL take priority over start and over button presses.
REQ-032 Reset asserted mid-game SHALL abandon the game with no partial write.

Structure
REQ-033 The state encoding, winner codes, the cell index constants (a=0..i=8) and the 8-line win table SHALL live in a shared package, tictactoe_pkg, which the ai stage also uses.
REQ-034 Line evaluation SHALL be a combinational sub-module, win_check (inputs: 9-bit mark vector; output: win flag), instantiated once with a mux selecting cells_x or cells_o.

Verification
REQ-035 The bench SHALL cover: reset, start, then P1 presses e -> cells_x = 9'h010, move_count = 1, and p1_turn = 0 two cycles after the press edge.
REQ-036 The bench SHALL cover: P1 a, P2 d, P1 b, P2 e, P1 c -> winner = 01, game_over = 1, state DONE, and a further press on i leaves cells unchanged.
REQ-037 The bench SHALL cover: a P2 press on cell e already held by P1 -> no change, p1_turn stays 0, move_count unchanged.
REQ-038 The bench SHALL cover: a_button and b_button rising in the same cycle -> both ignored; a held a_button for 5 cycles -> one move only.
REQ-039 The bench SHALL cover: the 9-move sequence e,a,c,g,d,f,b,h,i -> draw = 1, winner = 00, move_count = 9.
REQ-040 The bench SHALL cover: reset asserted in the same cycle as a valid press mid-game -> IDLE, all outputs 0; a following start -> P1_WAIT with ai_mode = game_mode.
